// File: rtl/calc_scheduler_pkg.sv
// Shared types for the two-client calculator scheduler: operand type,
// operation encoding, FSM states and the one-hot select bundle.
package calc_scheduler_pkg;

  typedef logic [15:0] uint16_t;

  typedef enum logic [1:0] {
    ADD = 2'd0,
    SUB = 2'd1,
    DIV = 2'd2,
    MUL = 2'd3
  } calc_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } sched_state_e;

  typedef struct packed {
    logic add;
    logic subtract;
    logic divide;
    logic multiply;
  } alu_sel_t;

  function automatic alu_sel_t decode_op(calc_op_e op);
    alu_sel_t sel;
    sel = '0;
    case (op)
      ADD: sel.add      = 1'b1;
      SUB: sel.subtract = 1'b1;
      DIV: sel.divide   = 1'b1;
      MUL: sel.multiply = 1'b1;
      default: sel = '0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/calc_rr_grant.sv
// Two-requester round-robin arbiter: a lone requester wins outright, a tie
// goes to the client that was not served last.
module calc_rr_grant (
  input  logic [1:0] req_valid,
  input  logic       last_served,
  output logic [1:0] grant
);

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves grant unassigned (no latch).
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_served ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/calc_scheduler.sv
// Shares one combinational UInt16 calculator between two clients: accepts a
// request, holds operands/selects for SETTLE_CYCLES, then returns the result.
module calc_scheduler
  import calc_scheduler_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic [1:0] req_op0,
  input  logic [1:0] req_op1,
  input  uint16_t    req_a0,
  input  uint16_t    req_b0,
  input  uint16_t    req_a1,
  input  uint16_t    req_b1,
  output logic [1:0] resp_valid,
  input  logic [1:0] resp_ready,
  output uint16_t    resp_result,
  output logic       resp_error,
  output uint16_t    alu_a,
  output uint16_t    alu_b,
  output logic       alu_add,
  output logic       alu_subtract,
  output logic       alu_divide,
  output logic       alu_multiply,
  input  uint16_t    alu_result,
  input  logic       alu_invalid,
  output logic       busy
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);

  sched_state_e  state;
  logic [CW-1:0] counter;
  logic          owner;
  logic          last_served;
  logic [1:0]    grant;
  alu_sel_t      sel_q;

  calc_rr_grant u_grant (
    .req_valid   (req_valid),
    .last_served (last_served),
    .grant       (grant)
  );

  // Ready is combinational so the handshake completes in the grant cycle.
  assign req_ready    = (state == IDLE && !rst) ? grant : 2'b00;
  assign busy         = (state != IDLE);
  assign alu_add      = sel_q.add;
  assign alu_subtract = sel_q.subtract;
  assign alu_divide   = sel_q.divide;
  assign alu_multiply = sel_q.multiply;

  // alu_a/alu_b/sel_q double as the operand latch; they are nonzero only in SETTLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      counter     <= '0;
      owner       <= 1'b0;
      last_served <= 1'b1;
      alu_a       <= '0;
      alu_b       <= '0;
      sel_q       <= '0;
      resp_valid  <= 2'b00;
      resp_result <= '0;
      resp_error  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state)
        IDLE: begin
          if (|grant) begin
            owner   <= grant[1];
            alu_a   <= grant[1] ? req_a1 : req_a0;
            alu_b   <= grant[1] ? req_b1 : req_b0;
            sel_q   <= decode_op(calc_op_e'(grant[1] ? req_op1 : req_op0));
            counter <= CNT_LOAD;
            state   <= SETTLE;
          end
        end
        SETTLE: begin
          if (counter == '0) begin
            resp_error  <= alu_invalid;
            resp_result <= alu_invalid ? '0 : alu_result;
            alu_a       <= '0;
            alu_b       <= '0;
            sel_q       <= '0;
            resp_valid  <= owner ? 2'b10 : 2'b01;
            state       <= RESP;
          end else begin
            counter <= counter - 1'b1;
          end
        end
        RESP: begin
          if (resp_ready[owner]) begin
            resp_valid  <= 2'b00;
            last_served <= owner;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_scheduler.sv
// Self-checking bench for calc_scheduler: bench-side calculator, a
// transaction-level reference model compared every cycle, directed and random stimulus.
module tb_calc_scheduler;

  localparam int S = 4;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_op0, req_op1;
  logic [15:0] req_a0, req_b0, req_a1, req_b1;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [15:0] resp_result;
  logic        resp_error;
  logic [15:0] alu_a, alu_b;
  logic        alu_add, alu_subtract, alu_divide, alu_multiply;
  logic [15:0] alu_result;
  logic        alu_invalid;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;

  calc_scheduler #(.SETTLE_CYCLES(S)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op0      (req_op0),
    .req_op1      (req_op1),
    .req_a0       (req_a0),
    .req_b0       (req_b0),
    .req_a1       (req_a1),
    .req_b1       (req_b1),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_result  (resp_result),
    .resp_error   (resp_error),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_add      (alu_add),
    .alu_subtract (alu_subtract),
    .alu_divide   (alu_divide),
    .alu_multiply (alu_multiply),
    .alu_result   (alu_result),
    .alu_invalid  (alu_invalid),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bench calculator; timing_mode makes the result move 7 -> 9 during settle.
  logic timing_mode;
  int   sel_age;

  always @(posedge clk or posedge rst) begin
    if (rst) sel_age <= 0;
    else     sel_age <= (alu_add | alu_subtract | alu_divide | alu_multiply) ? sel_age + 1 : 0;
  end

  always_comb begin
    alu_result  = 16'hBEEF;
    alu_invalid = 1'b1;
    if (alu_add) begin
      alu_result = alu_a + alu_b; alu_invalid = 1'b0;
    end else if (alu_subtract) begin
      alu_result = alu_a - alu_b; alu_invalid = 1'b0;
    end else if (alu_multiply) begin
      alu_result = alu_a * alu_b; alu_invalid = 1'b0;
    end else if (alu_divide) begin
      if (alu_b != 16'd0) begin
        alu_result = alu_a / alu_b; alu_invalid = 1'b0;
      end else begin
        alu_result = 16'hDEAD;
      end
    end
    if (timing_mode && !alu_invalid) alu_result = (sel_age >= S - 1) ? 16'd9 : 16'd7;
  end

  // {error, result} of one operation, from plain integer arithmetic.
  function automatic logic [16:0] model_calc(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    int unsigned ua, ub, r;
    ua = a; ub = b; r = 0;
    case (op)
      2'd0: r = (ua + ub) % 65536;
      2'd1: r = (ua + 65536 - ub) % 65536;
      2'd3: r = (ua * ub) % 65536;
      default: begin
        if (ub == 0) return {1'b1, 16'd0};
        r = ua / ub;
      end
    endcase
    return {1'b0, r[15:0]};
  endfunction

  // Reference model: a transaction occupies the datapath for S settle cycles,
  // then waits in a response slot until its owner takes it.
  logic        m_busy, m_resp, m_owner, m_last, m_err, g;
  int          m_left;
  logic [1:0]  m_op;
  logic [15:0] m_a, m_b, m_res;
  logic [1:0]  e_ready, e_rv;
  logic [3:0]  e_sel;
  logic [15:0] e_a, e_b;

  always @(negedge clk) begin
    if (rst) begin
      m_busy = 0; m_resp = 0; m_left = 0; m_owner = 0; m_last = 1;
      m_res = 0; m_err = 0; m_op = 0; m_a = 0; m_b = 0;
    end
    e_ready = 2'b00; e_rv = 2'b00; e_sel = 4'b0000; e_a = 0; e_b = 0; g = 0;
    if (!rst && !m_busy && req_valid != 2'b00) begin
      g = (req_valid == 2'b11) ? !m_last : req_valid[1];
      e_ready[g] = 1'b1;
    end
    if (m_left > 0) begin
      e_a = m_a; e_b = m_b;
      e_sel = 4'b1000 >> m_op;
      if (m_op == 2'd2) e_sel = 4'b0010;
      if (m_op == 2'd3) e_sel = 4'b0001;
    end
    if (m_resp) e_rv[m_owner] = 1'b1;

    check("req_ready",   req_ready, e_ready);
    check("resp_valid",  resp_valid, e_rv);
    check("resp_result", resp_result, m_res);
    check("resp_error",  resp_error, m_err);
    check("alu_a",       alu_a, e_a);
    check("alu_b",       alu_b, e_b);
    check("alu_sel",     {alu_add, alu_subtract, alu_divide, alu_multiply}, e_sel);
    check("busy",        busy, m_busy);

    if (!rst) begin
      if (m_resp) begin
        if (resp_ready[m_owner]) begin
          m_resp = 0; m_busy = 0; m_last = m_owner;
        end
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          {m_err, m_res} = model_calc(m_op, m_a, m_b);
          if (timing_mode && !m_err) m_res = 16'd9;
          m_resp = 1;
        end
      end else if (e_ready != 2'b00) begin
        m_busy = 1; m_left = S; m_owner = g;
        m_op = g ? req_op1 : req_op0;
        m_a  = g ? req_a1 : req_a0;
        m_b  = g ? req_b1 : req_b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_req(input int i, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    if (i == 0) begin req_op0 = op; req_a0 = a; req_b0 = b; end
    else        begin req_op1 = op; req_a1 = a; req_b1 = b; end
  endtask

  task automatic wait_resp(input string name);
    int n;
    n = 0;
    while (resp_valid == 2'b00 && n < 40) begin tick(); n++; end
    check({name, "_resp_seen"}, 32'(resp_valid != 2'b00), 1);
  endtask

  logic        grants[$];
  logic [15:0] results[$];
  logic [1:0]  acc;
  int          n;

  initial begin
    rst = 1'b1; req_valid = 2'b00; resp_ready = 2'b00; timing_mode = 1'b0;
    load_req(0, 2'd0, 16'd0, 16'd0);
    load_req(1, 2'd0, 16'd0, 16'd0);
    repeat (2) tick();
    check("rst_busy", busy, 0);
    check("rst_alu_a", alu_a, 0);
    rst = 1'b0;

    // Single ADD from client 0.
    load_req(0, 2'd0, 16'd1200, 16'd34); req_valid = 2'b01; resp_ready = 2'b11;
    #1 check("t1_ready", req_ready, 2'b01);
    tick(); req_valid = 2'b00;
    n = 0;
    while (alu_add === 1'b1 && n < 20) begin n++; tick(); end
    check("t1_add_cycles", n, S);
    check("t1_rv", resp_valid, 2'b01);
    check("t1_result", resp_result, 1234);
    check("t1_error", resp_error, 0);
    tick();

    // Divide by zero from client 1.
    load_req(1, 2'd2, 16'd500, 16'd0); req_valid = 2'b10;
    #1 check("t2_ready", req_ready, 2'b10);
    tick(); req_valid = 2'b00;
    n = 0;
    while (alu_divide === 1'b1 && n < 20) begin n++; tick(); end
    check("t2_div_cycles", n, S);
    check("t2_rv", resp_valid, 2'b10);
    check("t2_result", resp_result, 0);
    check("t2_error", resp_error, 1);
    tick();

    // Contention from reset: grants alternate 0,1,0,1.
    rst = 1'b1;
    load_req(0, 2'd3, 16'd300, 16'd300);
    load_req(1, 2'd1, 16'd5, 16'd7);
    req_valid = 2'b11; resp_ready = 2'b11;
    tick(); rst = 1'b0;
    for (int c = 0; c < 80 && results.size() < 4; c++) begin
      @(negedge clk);
      if (req_ready != 2'b00) grants.push_back(req_ready[1]);
      if (resp_valid != 2'b00) results.push_back(resp_result);
    end
    check("t3_grant_count", 32'(grants.size() >= 4), 1);
    check("t3_result_count", results.size(), 4);
    for (int i = 0; i < 4 && i < grants.size(); i++) check("t3_grant", grants[i], i % 2);
    for (int i = 0; i < results.size(); i++) check("t3_result", results[i], (i % 2 == 0) ? 24464 : 65534);
    tick(); req_valid = 2'b00;
    repeat (2) tick();

    // Backpressure on client 0 while client 1 waits.
    load_req(0, 2'd0, 16'd40000, 16'd30000); req_valid = 2'b01; resp_ready = 2'b10;
    tick();
    load_req(1, 2'd1, 16'd9, 16'd3); req_valid = 2'b10;
    wait_resp("t4");
    check("t4_rv", resp_valid, 2'b01);
    check("t4_result", resp_result, 4464);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t4_hold_rv", resp_valid, 2'b01);
      check("t4_hold_result", resp_result, 4464);
      check("t4_hold_ready", req_ready, 2'b00);
    end
    resp_ready = 2'b11;
    tick();
    check("t4_next_ready", req_ready, 2'b10);
    tick(); req_valid = 2'b00;
    wait_resp("t4b");
    check("t4b_rv", resp_valid, 2'b10);
    check("t4b_result", resp_result, 6);
    tick();

    // Result sampled only in the last settle cycle.
    timing_mode = 1'b1;
    load_req(0, 2'd0, 16'd1, 16'd1); req_valid = 2'b01;
    tick(); req_valid = 2'b00;
    wait_resp("t5");
    check("t5_result", resp_result, 9);
    tick(); timing_mode = 1'b0;

    // Reset in the second settle cycle.
    load_req(0, 2'd0, 16'd10, 16'd20);
    load_req(1, 2'd3, 16'd3, 16'd4);
    req_valid = 2'b11;
    tick(); tick();
    check("t6_in_settle", busy, 1);
    rst = 1'b1;
    #1;
    check("t6_busy", busy, 0);
    check("t6_alu_a", alu_a, 0);
    check("t6_sel", {alu_add, alu_subtract, alu_divide, alu_multiply}, 0);
    check("t6_rv", resp_valid, 0);
    check("t6_ready", req_ready, 0);
    check("t6_result", resp_result, 0);
    tick(); rst = 1'b0;
    #1 check("t6_tie_ready", req_ready, 2'b01);
    tick();
    wait_resp("t6");
    check("t6_first_rv", resp_valid, 2'b01);
    check("t6_first_result", resp_result, 30);
    tick(); req_valid = 2'b00;
    repeat (S + 4) tick();

    // Randomized traffic with random backpressure.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      tick();
      for (int i = 0; i < 2; i++) begin
        if (acc[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          load_req(i, 2'($urandom_range(0, 3)),
                   ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom),
                   ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(0, 1) == 0 ? $urandom_range(1, 20) : $urandom));
          req_valid[i] = 1'b1;
        end
      end
      resp_ready = 2'($urandom_range(0, 3));
    end
    req_valid = 2'b00; resp_ready = 2'b11;
    repeat (S + 6) tick();
    check("final_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
